dffe_fifo_reader: RTL and testbench
===================================

Name: dffe_fifo_reader

Overview:
- Small synchronous FIFO built from enable-gated, async-clear storage registers.
- The write side is a plain enable strobe, the same as a register write.
- The read side is a valid/ready consumer handshake with show-ahead data.
- Used to hand results from processor-side producers (e.g. multdiv results, stage outputs) to a consumer that may stall, without losing writes.

Parameters:
- WIDTH, 32, data bits per entry.
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- ADDR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset, asynchronous, active-high; clears all state immediately.
- wr_en  input  1  write strobe; sampled on clk rising edge.
- wr_data  input  WIDTH  data written when the write is accepted.
- full  output  1  high when count == DEPTH.
- rd_valid  output  1  high when count != 0; head entry is presented on rd_data.
- rd_ready  input  1  consumer accepts the head entry this cycle.
- rd_data  output  WIDTH  head entry when rd_valid=1; all zeros when rd_valid=0.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- ovf  output  1  present only with DFFE_FIFO_OVF_EN (see Optional Feature).

Behaviour:
- Reset (clr=1, asynchronous, no clock needed):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage entries cleared to 0.
  - full=0, rd_valid=0, rd_data=0, ovf=0.
  - clr has priority over every other input.
  - clr asserted mid-stream discards all contents. The first write after clr deasserts lands in entry 0.
- Push: occurs at the clk rising edge when wr_en=1 and full=0.
  - wr_data is stored at wr_ptr.
  - wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
- Pop: occurs at the clk rising edge when rd_valid=1 and rd_ready=1.
  - rd_ptr increments modulo DEPTH.
  - The popped entry's storage is not cleared.
- Show-ahead read:
  - rd_data is combinational from storage[rd_ptr], masked to 0 when count==0.
  - Zero-latency read: data is visible in the same cycle rd_valid rises.
- Write latency: a push at edge N makes rd_valid=1 and shows the data after edge N when the FIFO was empty. There is no bypass of wr_data to rd_data within the same cycle.
- Count updates:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full boundary:
  - wr_en while full=0 is always accepted.
  - wr_en while full=1 is dropped. No storage or pointer change, even if a pop occurs in the same cycle.
  - On full with a simultaneous pop, count goes to DEPTH-1 and full clears after the edge.
- Empty boundary:
  - rd_ready while rd_valid=0 is ignored.
  - wr_en with rd_ready while empty: push accepted, no pop; count goes to 1.
- rd_ready may be held high continuously; one entry drains per cycle.
- rd_valid is not required to stay asserted without a pop, but data at the head is stable until popped or until clr.
- Outputs full, rd_valid and count are registered-state decodes. They are glitch-free with respect to wr_en and rd_ready.
- No X propagation out of reset: every register is initialized to 0 and also cleared by clr.

Optional Feature:
- Macro: DFFE_FIFO_OVF_EN.
- Defined:
  - Output ovf exists.
  - ovf is sticky: set to 1 at the rising edge where wr_en=1 and full=1 (a dropped write).
  - ovf stays 1 until clr; it is cleared only by clr.
  - ovf does not affect the data path.
- Undefined:
  - No ovf port and no ovf register.
  - Dropped writes are silent.
  - All other behaviour is identical.

Test Plan:
- clr pulse with no clock edge, after prior writes -> count=0, rd_valid=0, rd_data=0, full=0 immediately.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles with rd_ready=0 (DEPTH=4) -> count steps 1,2,3,4; full=1 after 4th edge; rd_data=0x11 from edge 1 onward.
- With FIFO full, wr_en=1 with 0x55 -> dropped; count stays 4. Then drain with rd_ready=1 -> rd_data sequence 0x11,0x22,0x33,0x44, then rd_valid=0. With DFFE_FIFO_OVF_EN, ovf=1 persists after the drain.
- Hold count=2, assert wr_en with 0xA5 and rd_ready=1 for 6 cycles -> count stays 2; pointers wrap past entry 3; output order matches input order exactly.
- Empty FIFO, wr_en=1 with 0x7 and rd_ready=1 in the same cycle -> after the edge count=1, rd_valid=1, rd_data=0x7; the entry is not lost.
- Full FIFO, wr_en=1 with 0x99 and rd_ready=1 -> pop occurs, write dropped; count=3, full=0; 0x99 never appears on rd_data.

Source files
------------

// File: rtl/dffe_fifo_reader.sv
// dffe_fifo_reader: small FIFO of enable-gated, async-clear registers; strobe write, valid/ready show-ahead read.
// Optional: define DFFE_FIFO_OVF_EN to add the sticky ovf (dropped write) output.
// Ports: clk, clr (async active-high), wr_en/wr_data (write strobe), full,
//        rd_valid/rd_ready/rd_data (show-ahead consumer handshake), count, [ovf]
module dffe_fifo_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count
`ifdef DFFE_FIFO_OVF_EN
  ,
  output logic              ovf
`endif
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop;
  assign full     = count == (ADDR_W+1)'(DEPTH);
  assign rd_valid = count != '0;
  assign push     = wr_en && !full;
  assign pop      = rd_valid && rd_ready;
  // masked so an empty FIFO never exposes stale popped entries
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
`ifdef DFFE_FIFO_OVF_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) ovf <= 1'b0;
    else if (wr_en && full) ovf <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_dffe_fifo_reader.sv
// tb_dffe_fifo_reader: directed self-checking bench for dffe_fifo_reader (DEPTH=4, WIDTH=32).
module tb_dffe_fifo_reader;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        full, rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic [2:0]  count;
  int          checks = 0;
  int          errors = 0;
`ifdef DFFE_FIFO_OVF_EN
  logic        ovf;
`endif
  dffe_fifo_reader #(.WIDTH(32), .DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count)
`ifdef DFFE_FIFO_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic we, input logic [31:0] wd, input logic rr);
    wr_en = we;
    wr_data = wd;
    rd_ready = rr;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] q[$];
    logic [31:0] v;
    #2;
    chk("reset count", 32'(count), 0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset full", 32'(full), 0);
`ifdef DFFE_FIFO_OVF_EN
    chk("reset ovf", 32'(ovf), 0);
`endif
    @(posedge clk);
    #1 clr = 1'b0;
    step(1, 32'hDEAD, 0);
    step(1, 32'hBEEF, 0);
    chk("pre-clr count", 32'(count), 2);
    #2 clr = 1'b1;
    #1;
    chk("async clr count", 32'(count), 0);
    chk("async clr rd_valid", 32'(rd_valid), 0);
    chk("async clr rd_data", rd_data, 0);
    chk("async clr full", 32'(full), 0);
    #1 clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h11 * (i + 1), 0);
      chk("fill count", 32'(count), 32'(i + 1));
      chk("fill head", rd_data, 32'h11);
      chk("fill full", 32'(full), i == 3 ? 1 : 0);
    end
    step(1, 32'h55, 0);
    chk("drop count", 32'(count), 4);
    chk("drop full", 32'(full), 1);
`ifdef DFFE_FIFO_OVF_EN
    chk("ovf set", 32'(ovf), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("drain valid", 32'(rd_valid), 1);
      chk("drain data", rd_data, 32'h11 * (i + 1));
      step(0, 0, 1);
    end
    chk("drained valid", 32'(rd_valid), 0);
    chk("drained data", rd_data, 0);
    chk("drained count", 32'(count), 0);
`ifdef DFFE_FIFO_OVF_EN
    chk("ovf sticky", 32'(ovf), 1);
`endif
    step(0, 0, 1);
    chk("empty pop ignored", 32'(count), 0);
    step(1, 32'h01, 0);
    step(1, 32'h02, 0);
    q.push_back(32'h01);
    q.push_back(32'h02);
    for (int i = 0; i < 6; i++) begin
      v = 32'hA5 + 32'(i);
      chk("stream head", rd_data, q[0]);
      void'(q.pop_front());
      q.push_back(v);
      step(1, v, 1);
      chk("stream count", 32'(count), 2);
    end
    while (q.size() > 0) begin
      chk("stream tail", rd_data, q.pop_front());
      step(0, 0, 1);
    end
    chk("stream empty", 32'(count), 0);
    step(1, 32'h7, 1);
    chk("empty wr+rd count", 32'(count), 1);
    chk("empty wr+rd valid", 32'(rd_valid), 1);
    chk("empty wr+rd data", rd_data, 32'h7);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'hC0 + 32'(i), 0);
    chk("refill full", 32'(full), 1);
    step(1, 32'h99, 1);
    chk("full wr+rd count", 32'(count), 3);
    chk("full wr+rd full", 32'(full), 0);
    for (int i = 1; i < 4; i++) begin
      chk("no 0x99", rd_data, 32'hC0 + 32'(i));
      step(0, 0, 1);
    end
    chk("final empty", 32'(rd_valid), 0);
    clr = 1'b1;
    #1 clr = 1'b0;
    step(1, 32'h3C, 0);
    chk("post-clr head", rd_data, 32'h3C);
    chk("post-clr count", 32'(count), 1);
`ifdef DFFE_FIFO_OVF_EN
    chk("ovf cleared", 32'(ovf), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
